clause_queue_bank: RTL and testbench
====================================

Name: clause_queue_bank

Overview:
- Receiving end of the clause-distribution interface.
- Holds one clause FIFO per solver engine, driven by the round-robin clause arbiter.
- Accepts the broadcast clause bus into every queue whose grant bit is set.
- Reports per-queue full status back to the arbiter as its request-mask source, and presents each queue head to its engine with a valid/pop handshake.

Parameters:
- OUTPUT_CNT, 4, number of engine queues (matches arbiter grant width).
- CLAUSE_WIDTH, 4, literals per clause.
- ELEMENT_CNT, 1024, variable count. Literal width ELEM_BITS = $clog2(ELEMENT_CNT)+1 (sign bit included).
- DEPTH, 4, entries per queue. Must be a power of 2 and >= 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clause_in  in  CLAUSE_WIDTH*ELEM_BITS  clause broadcast from the arbiter
- grant_in  in  OUTPUT_CNT  per-queue write strobe; normally one-hot or zero
- full_out  out  OUTPUT_CNT  queue i holds DEPTH entries
- pop_in  in  OUTPUT_CNT  engine i consumes the head entry
- valid_out  out  OUTPUT_CNT  queue i head is valid
- clause_out  out  OUTPUT_CNT*CLAUSE_WIDTH*ELEM_BITS  head clause of queue i, slice i
- err_out  out  OUTPUT_CNT  sticky: a grant arrived while queue i was full

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Per-queue state:
  - wr_ptr, rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
  - storage array, DEPTH x clause bits.
- Output decode:
  - full_out[i] = (count_i == DEPTH), decoded purely from registered count.
  - valid_out[i] = (count_i != 0).
- Push condition: push_i = grant_in[i] & ~full_out[i]. It writes clause_in at wr_ptr_i and increments wr_ptr_i.
- Pop condition: pop_eff_i = pop_in[i] & valid_out[i]. It increments rd_ptr_i.
- Count update: count_i += push_i - pop_eff_i. Simultaneous push and pop leaves count unchanged.
- Full queue with simultaneous pop: push is still rejected, because full is decoded from the registered count. The pop proceeds, and count becomes DEPTH-1.
- Pop while empty: ignored; no pointer change.
- Grant while full: data dropped; err_out[i] sets and stays set until reset.
- Multi-bit grant_in: each granted, non-full queue writes the same clause independently. No error is raised.
- Head output: clause_out slice i = storage_i[rd_ptr_i] when valid_out[i], else all zeros.
- Latency: a push in cycle N makes the entry visible at valid_out/clause_out in cycle N+1. full_out changes in the cycle after the push or pop that causes it.
- Ordering: strict FIFO per queue. Queues are fully independent.
- Reset (at start or mid-operation) clears:
  - pointers, counts and err_out;
  - all valid_out, full_out and err_out to 0;
  - clause_out to 0.
  - Storage contents are not cleared. Any push or pop in the reset cycle is discarded.

Optional Feature:
- Macro: CQ_BYPASS_EN.
- When defined, an empty queue gives first-word fall-through in the same cycle:
  - If count_i == 0 and grant_in[i], then valid_out[i] = 1 and clause_out slice i = clause_in combinationally.
  - If pop_in[i] is also high that cycle, the clause is consumed directly and not stored; count stays 0.
  - If not popped, the clause is stored normally.
- When undefined, behaviour is as above: write-to-valid latency is 1 cycle and no combinational path exists from clause_in to clause_out.

Test Plan:
- Reset and idle:
  - Stimulus: assert reset 2 cycles with grant_in=4'b1111.
  - Required: full_out=0, valid_out=0, err_out=0, clause_out=0; no entries after reset drops.
- Fill and drain queue 2 (DEPTH=4):
  - Stimulus: grant_in=4'b0100 with clauses 0x11..,0x22..,0x33..,0x44.. over 4 cycles.
  - Required: full_out[2]=1 the following cycle. Popping 4 times returns clauses in order, then valid_out[2]=0.
- Overflow:
  - Stimulus: with queue 0 full, grant_in=4'b0001 with clause 0xAA...
  - Required: the clause is dropped, err_out[0]=1 sticky, and the queue head is unchanged.
- Simultaneous push/pop at count 2:
  - Required: count stays 2 and the head advances.
  - Stimulus: at count 4, push+pop.
  - Required: push is rejected, count becomes 3, err_out is set.
- Wrap-around: 10 interleaved push/pop on queue 3 → pointers wrap and data order is preserved.
- Reset mid-operation and bypass:
  - Stimulus: reset with queues partially full, then grant+pop on empty queue 1.
  - Required: all queues are empty after reset.
  - With CQ_BYPASS_EN: the clause appears the same cycle and count stays 0.
  - Without CQ_BYPASS_EN: valid_out rises next cycle.

Source files
------------

// File: rtl/clause_queue_bank.sv
// Per-engine clause FIFOs fed by the broadcast clause bus under arbiter grant.
// Optional macro CQ_BYPASS_EN: first-word fall-through when a queue is empty.
module clause_queue_bank #(
  parameter  int OUTPUT_CNT   = 4,
  parameter  int CLAUSE_WIDTH = 4,
  parameter  int ELEMENT_CNT  = 1024,
  parameter  int DEPTH        = 4,
  localparam int ELEM_BITS    = $clog2(ELEMENT_CNT) + 1,
  localparam int CL_W         = CLAUSE_WIDTH * ELEM_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CL_W-1:0]            clause_in,
  input  logic [OUTPUT_CNT-1:0]      grant_in,
  output logic [OUTPUT_CNT-1:0]      full_out,
  input  logic [OUTPUT_CNT-1:0]      pop_in,
  output logic [OUTPUT_CNT-1:0]      valid_out,
  output logic [OUTPUT_CNT*CL_W-1:0] clause_out,
  output logic [OUTPUT_CNT-1:0]      err_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  for (genvar i = 0; i < OUTPUT_CNT; i++) begin : g_q
    logic [CL_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;
    logic             nonempty;
    logic             byp_take;
    logic             push;
    logic             pop_eff;

    // Head decode: status comes only from the registered count
    assign nonempty    = (count != '0);
    assign full_out[i] = (count == CNT_W'(DEPTH));
    assign err_out[i]  = err_q;

`ifdef CQ_BYPASS_EN
    logic byp_hit;
    assign byp_hit      = ~nonempty & grant_in[i];
    assign valid_out[i] = nonempty | byp_hit;
    assign byp_take     = byp_hit & pop_in[i];
    assign clause_out[i*CL_W +: CL_W] = nonempty ? mem[rd_ptr] :
                                        (byp_hit ? clause_in : '0);
`else
    assign valid_out[i] = nonempty;
    assign byp_take     = 1'b0;
    assign clause_out[i*CL_W +: CL_W] = nonempty ? mem[rd_ptr] : '0;
`endif

    // A clause consumed straight through the bypass is never stored
    assign push    = grant_in[i] & ~full_out[i] & ~byp_take;
    assign pop_eff = pop_in[i] & nonempty;

    // Control state update
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        err_q  <= 1'b0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + 1'b1;
        if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop_eff})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (grant_in[i] && full_out[i]) err_q <= 1'b1;
      end
    end

    // Storage: contents survive reset; stale writes are invisible once pointers clear
    always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= clause_in;
    end
  end

endmodule

// File: tb/tb_clause_queue_bank.sv
// Directed bench for clause_queue_bank with a queue-based reference model.
module tb_clause_queue_bank;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CL_W  = 44;
`ifdef CQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [CL_W-1:0] clause_in;
  logic [N-1:0]    grant_in, pop_in;
  logic [N-1:0]    full_out, valid_out, err_out;
  logic [N*CL_W-1:0] clause_out;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  logic [CL_W-1:0] mq [N][$];
  logic [N-1:0]    merr;

  clause_queue_bank #(.OUTPUT_CNT(N), .CLAUSE_WIDTH(4), .ELEMENT_CNT(1024), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clause_in(clause_in), .grant_in(grant_in),
    .full_out(full_out), .pop_in(pop_in), .valid_out(valid_out),
    .clause_out(clause_out), .err_out(err_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [N*CL_W-1:0] act, input logic [N*CL_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CL_W-1:0] rep(input logic [3:0] n);
    return {11{n}};
  endfunction

  function automatic logic [CL_W-1:0] head(input int i);
    return clause_out[i*CL_W +: CL_W];
  endfunction

  // Reference model: each queue is a plain FIFO bounded at DEPTH entries
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        mq[i].delete();
        merr[i] = 1'b0;
      end else begin
        automatic bit was_full  = (mq[i].size() == DEPTH);
        automatic bit was_empty = (mq[i].size() == 0);
        automatic bit through   = BYP && was_empty && grant_in[i] && pop_in[i];
        if (grant_in[i] && was_full) merr[i] = 1'b1;
        if (pop_in[i] && !was_empty) void'(mq[i].pop_front());
        if (grant_in[i] && !was_full && !through) mq[i].push_back(clause_in);
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      logic [N-1:0]      ev, ef;
      logic [N*CL_W-1:0] ec;
      for (int i = 0; i < N; i++) begin
        ef[i] = (mq[i].size() == DEPTH);
        ev[i] = (mq[i].size() != 0) || (BYP && grant_in[i]);
        if (mq[i].size() != 0)         ec[i*CL_W +: CL_W] = mq[i][0];
        else if (BYP && grant_in[i])   ec[i*CL_W +: CL_W] = clause_in;
        else                           ec[i*CL_W +: CL_W] = '0;
      end
      chk("model_valid", N*CL_W'(valid_out), N*CL_W'(ev));
      chk("model_full",  N*CL_W'(full_out),  N*CL_W'(ef));
      chk("model_err",   N*CL_W'(err_out),   N*CL_W'(merr));
      chk("model_clause", clause_out, ec);
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] g, input logic [CL_W-1:0] c, input logic [N-1:0] p);
    reset = r; grant_in = g; clause_in = c; pop_in = p;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic r, input logic [N-1:0] g, input logic [CL_W-1:0] c, input logic [N-1:0] p);
    drive(r, g, c, p);
    tick();
  endtask

  initial begin
    // Reset with all grants asserted: nothing may be captured
    step(1'b1, 4'b1111, rep(4'h9), 4'b0000);
    started = 1'b1;
    step(1'b1, 4'b1111, rep(4'h9), 4'b0000);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("rst_full",   N*CL_W'(full_out),  '0);
    chk("rst_valid",  N*CL_W'(valid_out), '0);
    chk("rst_err",    N*CL_W'(err_out),   '0);
    chk("rst_clause", clause_out,         '0);

    // Fill and drain queue 2
    for (int k = 1; k <= 4; k++) step(1'b0, 4'b0100, rep(4'(k)), 4'b0000);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("fill_full",  N*CL_W'(full_out),  N*CL_W'(4'b0100));
    chk("fill_head",  CL_W'(head(2)),     rep(4'h1));
    for (int k = 1; k <= 4; k++) begin
      chk("drain_head", CL_W'(head(2)), rep(4'(k)));
      step(1'b0, 4'b0000, '0, 4'b0100);
    end
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("drain_empty", N*CL_W'(valid_out), '0);

    // Overflow on queue 0
    for (int k = 5; k <= 8; k++) step(1'b0, 4'b0001, rep(4'(k)), 4'b0000);
    step(1'b0, 4'b0001, rep(4'hA), 4'b0000);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("ovf_err",  N*CL_W'(err_out),  N*CL_W'(4'b0001));
    chk("ovf_head", CL_W'(head(0)),    rep(4'h5));
    chk("ovf_full", N*CL_W'(full_out), N*CL_W'(4'b0001));

    // Push+pop while full: push rejected, count drops to 3
    step(1'b0, 4'b0001, rep(4'hB), 4'b0001);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("fullpp_full", N*CL_W'(full_out), '0);
    chk("fullpp_head", CL_W'(head(0)),    rep(4'h6));
    chk("fullpp_err",  N*CL_W'(err_out),  N*CL_W'(4'b0001));
    // Down to count 2, then push+pop keeps count and advances head
    step(1'b0, 4'b0000, '0, 4'b0001);
    step(1'b0, 4'b0001, rep(4'hC), 4'b0001);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("pp2_head", CL_W'(head(0)), rep(4'h8));
    step(1'b0, 4'b0000, '0, 4'b0001);
    chk("pp2_next", CL_W'(head(0)), rep(4'hC));
    step(1'b0, 4'b0000, '0, 4'b0001);
    chk("pp2_empty", N*CL_W'(valid_out[0]), '0);

    // Wrap-around on queue 3: push every cycle, pop from the second cycle on
    for (int k = 0; k < 10; k++)
      step(1'b0, 4'b1000, {4'(k), 40'h0_1234_5678 ^ 40'(k)}, (k == 0) ? 4'b0000 : 4'b1000);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("wrap_head", CL_W'(head(3)), {4'd9, 40'h0_1234_5678 ^ 40'd9});
    step(1'b0, 4'b0000, '0, 4'b1000);

    // Reset mid-operation with several queues occupied
    step(1'b0, 4'b0111, rep(4'hD), 4'b0000);
    step(1'b0, 4'b0001, rep(4'hE), 4'b0000);
    step(1'b1, 4'b0010, rep(4'hF), 4'b0001);
    step(1'b0, 4'b0000, '0, 4'b0000);
    chk("mrst_valid", N*CL_W'(valid_out), '0);
    chk("mrst_err",   N*CL_W'(err_out),   '0);
    chk("mrst_clause", clause_out,        '0);

    // Grant+pop on empty queue 1
    drive(1'b0, 4'b0010, rep(4'h7), 4'b0010);
    #1;
    chk("byp_same_valid", N*CL_W'(valid_out), BYP ? N*CL_W'(4'b0010) : '0);
    chk("byp_same_clause", CL_W'(head(1)), BYP ? rep(4'h7) : '0);
    tick();
    drive(1'b0, 4'b0000, '0, 4'b0000);
    #1;
    chk("byp_next_valid", N*CL_W'(valid_out), BYP ? '0 : N*CL_W'(4'b0010));
    chk("byp_next_clause", CL_W'(head(1)), BYP ? '0 : rep(4'h7));
    tick();
    step(1'b0, 4'b0000, '0, 4'b0010);
    step(1'b0, 4'b0000, '0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
